// File: rtl/etapa_mem.sv
// Memory-access stage: issues loads/stores to a multi-cycle data memory over
// req/ack, stalls upstream while the access is outstanding and feeds MEM_WB.
module etapa_mem #(
  parameter int TIMEOUT = 15
) (
  input  logic        reloj,
  input  logic        resetMEM,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ctrl_WB_ex,
  input  logic [31:0] DIR_in,
  input  logic [31:0] DI_in,
  input  logic [4:0]  Y_MUX_ex,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall_mem,
  output logic [1:0]  ctrl_WB_mem,
  output logic [31:0] DO,
  output logic [31:0] DIR,
  output logic [4:0]  Y_MUX_mem,
  output logic        mem_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Last counter value at which a missing ack aborts the access
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] do_reg_q, do_reg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        abort_q, abort_d;

  logic op;
  logic aligned;

  assign op      = MemRead | MemWrite;
  assign aligned = (DIR_in[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    do_reg_d    = do_reg_q;
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
    abort_d     = abort_q;
    case (state_q)
      S_IDLE: begin
        if (op && !aligned) begin
          mem_err_d = 1'b1;
        end else if (op) begin
          // A simultaneous read+write request is treated as a store
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite;
          mem_addr_d  = {DIR_in[31:2], 2'b00};
          mem_wdata_d = DI_in;
          cnt_d       = 8'd0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          do_reg_d  = mem_we_q ? 32'd0 : mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        do_reg_d = 32'd0;
        abort_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetMEM) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      do_reg_q    <= 32'd0;
      cnt_q       <= 8'd0;
      mem_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      do_reg_q    <= do_reg_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= mem_err_d;
      abort_q     <= abort_d;
    end
  end

  // Fields presented to MEM_WB; bubbles carry no register write and no data
  always_comb begin
    stall_mem   = 1'b0;
    ctrl_WB_mem = 2'b00;
    DO          = 32'd0;
    case (state_q)
      S_IDLE: begin
        stall_mem   = op && aligned;
        ctrl_WB_mem = op ? 2'b00 : ctrl_WB_ex;
      end
      S_WAIT: begin
        stall_mem = 1'b1;
      end
      S_DONE: begin
        ctrl_WB_mem = abort_q ? 2'b00 : ctrl_WB_ex;
        DO          = do_reg_q;
      end
      default: begin
        stall_mem = 1'b0;
      end
    endcase
  end

  assign DIR       = DIR_in;
  assign Y_MUX_mem = Y_MUX_ex;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;

endmodule
